alarm_clk_btn_debounce: RTL and testbench

ALARM_CLK_BTN_DEBOUNCE -- requirements
Module: alarm_clk_btn_debounce

---
 rtl/alarm_clk_btn_debounce.sv | 188 ++++++++++++++++++
 tb/tb_alarm_clk_btn_debounce.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clk_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : alarm_clk_btn_debounce
// Description : Push-button conditioner. Synchronizes the raw active-low
//               board button, debounces both edges with a four-state FSM
//               and produces a registered level plus one-cycle press and
//               release pulses.
//               Optional macro ALARM_CLK_BTN_AUTOREPEAT_EN adds auto-repeat
//               press pulses while the button is held.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_clk_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Reject illegal configurations at elaboration time.
    generate
        if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
            $error("alarm_clk_btn_debounce: all timing parameters must be >= 1");
        end
    endgenerate

    logic               r_sync_0;
    logic               r_sync_1;
    logic               w_press;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               r_level;
    logic               w_level_nxt;
    logic               r_press;
    logic               w_press_nxt;
    logic               r_release;
    logic               w_release_nxt;
    logic               w_rep_fire;

    // Two-flop synchronizer; resets to the released level (1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_0 <= 1'b1;
            r_sync_1 <= 1'b1;
        end else begin
            r_sync_0 <= btn_n_raw;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_press = ~r_sync_1;

`ifdef ALARM_CLK_BTN_AUTOREPEAT_EN
    localparam int                 C_REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                 C_REP_W      = $clog2(C_REP_MAX + 1);
    localparam logic [C_REP_W-1:0] C_DELAY_LAST  = C_REP_W'(REPEAT_DELAY - 1);
    localparam logic [C_REP_W-1:0] C_PERIOD_LAST = C_REP_W'(REPEAT_PERIOD - 1);

    logic [C_REP_W-1:0] r_rep_cnt;
    logic               r_rep_armed;

    // First repeat waits the long delay; later repeats use the short period.
    always_comb begin
        w_rep_fire = 1'b0;
        if ((r_state == ST_HELD) && w_press &&
            (r_rep_cnt == (r_rep_armed ? C_PERIOD_LAST : C_DELAY_LAST))) begin
            w_rep_fire = 1'b1;
        end
    end

    // Repeat counter runs only while staying in HELD; any other path zeroes it,
    // so every (re-)entry into HELD starts a fresh delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if ((r_state == ST_HELD) && (w_state_nxt == ST_HELD)) begin
            if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + 1'b1;
            end
        end else begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Debounce FSM next-state and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_press) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_press) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_rep_fire) begin
                    w_press_nxt = 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_press) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, debounce counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clk_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_clk_btn_debounce
// Description : Directed self-checking bench for alarm_clk_btn_debounce with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clk_btn_debounce;

    localparam int C_DB  = 4;
    localparam int C_RD  = 20;
    localparam int C_RP  = 8;
`ifdef ALARM_CLK_BTN_AUTOREPEAT_EN
    localparam bit C_AR  = 1'b1;
`else
    localparam bit C_AR  = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic btn_n_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    int checks      = 0;
    int errors      = 0;
    int edge_cnt    = 0;
    int press_cnt   = 0;
    int release_cnt = 0;
    int viol_cnt    = 0;
    int press_edges[$];
    logic prev_level = 1'b0;
    int base;
    int exp_press_n;
    int exp_off[6] = '{7, 27, 35, 43, 51, 59};

    alarm_clk_btn_debounce #(
        .DEBOUNCE_CYCLES (C_DB),
        .REPEAT_DELAY    (C_RD),
        .REPEAT_PERIOD   (C_RP)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_n_raw   (btn_n_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    // Rising-edge index, read on the falling edge that follows.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Pulse bookkeeping and level/pulse consistency tracking.
    always @(negedge clk) begin
        if (btn_press) begin
            press_cnt++;
            press_edges.push_back(edge_cnt);
        end
        if (btn_release) release_cnt++;
        if (reset_n) begin
            if (btn_press && btn_release) viol_cnt++;
            if (btn_level && !prev_level && !btn_press) viol_cnt++;
            if (!btn_level && prev_level && !btn_release) viol_cnt++;
        end
        prev_level = btn_level;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        press_cnt   = 0;
        release_cnt = 0;
        press_edges.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        btn_n_raw = 1'b1;
        wait_n(3);
        check_eq("rst_level",   btn_level,   0);
        check_eq("rst_press",   btn_press,   0);
        check_eq("rst_release", btn_release, 0);
        reset_n = 1'b1;
        wait_n(3);
        clear_counts();

        // Clean press held through the auto-repeat window.
        btn_n_raw = 1'b0;
        base = edge_cnt;
        wait_n(6);
        check_eq("press_level_e6", btn_level, 0);
        check_eq("press_pulse_e6", btn_press, 0);
        wait_n(1);
        check_eq("press_level_e7", btn_level, 1);
        check_eq("press_pulse_e7", btn_press, 1);
        wait_n(1);
        check_eq("press_pulse_e8", btn_press, 0);
        check_eq("press_level_e8", btn_level, 1);
        wait_n(58);
        exp_press_n = C_AR ? 6 : 1;
        check_eq("press_count", press_cnt, exp_press_n);
        for (int i = 0; i < exp_press_n; i++) begin
            if (i < press_edges.size())
                check_eq("press_offset", press_edges[i] - base, exp_off[i]);
        end
        check_eq("press_no_release", release_cnt, 0);

        // Two-cycle release glitch while held.
        clear_counts();
        btn_n_raw = 1'b1;
        wait_n(2);
        btn_n_raw = 1'b0;
        wait_n(8);
        check_eq("glitch_level",   btn_level,   1);
        check_eq("glitch_release", release_cnt, 0);
        check_eq("glitch_press",   press_cnt,   C_AR ? 1 : 0);
        if (C_AR && (press_edges.size() > 0))
            check_eq("glitch_rep_offset", press_edges[0] - base, 67);

        // Sustained release.
        clear_counts();
        btn_n_raw = 1'b1;
        base = edge_cnt;
        wait_n(6);
        check_eq("rel_level_e6", btn_level, 1);
        wait_n(1);
        check_eq("rel_level_e7", btn_level,   0);
        check_eq("rel_pulse_e7", btn_release, 1);
        wait_n(1);
        check_eq("rel_pulse_e8", btn_release, 0);
        wait_n(10);
        check_eq("rel_count",    release_cnt, 1);
        check_eq("rel_no_press", press_cnt,   0);

        // Bounce: low 3, high 2, low 3, then released.
        clear_counts();
        btn_n_raw = 1'b0;
        wait_n(3);
        btn_n_raw = 1'b1;
        wait_n(2);
        btn_n_raw = 1'b0;
        wait_n(3);
        btn_n_raw = 1'b1;
        wait_n(12);
        check_eq("bounce_level",   btn_level,   0);
        check_eq("bounce_press",   press_cnt,   0);
        check_eq("bounce_release", release_cnt, 0);

        // Reset in the middle of PRESS_WAIT with the button kept down.
        clear_counts();
        btn_n_raw = 1'b0;
        wait_n(5);
        reset_n = 1'b0;
        wait_n(3);
        check_eq("rstpw_level",   btn_level,   0);
        check_eq("rstpw_press",   press_cnt,   0);
        check_eq("rstpw_release", btn_release, 0);
        reset_n = 1'b1;
        base = edge_cnt;
        wait_n(6);
        check_eq("rstpw_level_e6", btn_level, 0);
        wait_n(1);
        check_eq("rstpw_level_e7", btn_level, 1);
        check_eq("rstpw_pulse_e7", btn_press, 1);
        wait_n(1);
        check_eq("rstpw_pulse_e8", btn_press, 0);
        wait_n(5);
        check_eq("rstpw_press_count", press_cnt, 1);

        // Asynchronous reset while held clears the level without a clock.
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_level", btn_level, 0);
        wait_n(2);
        btn_n_raw = 1'b1;
        reset_n   = 1'b1;
        wait_n(8);
        check_eq("rsthold_press",   press_cnt,   1);
        check_eq("rsthold_release", release_cnt, 0);
        check_eq("rsthold_level",   btn_level,   0);

        check_eq("level_pulse_consistency", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
